// File: rtl/dm_access_ctrl.sv
// Two-port round-robin access controller for a word-only DataMemory.
// Handles RV32I sub-word loads with extension and sub-word stores as read-modify-write.
module dm_access_ctrl #(
  parameter int unsigned DEPTH = 255
) (
  input  logic        i_dac_clk,
  input  logic        i_dac_rst_n,
  input  logic        i_dac_req0,
  input  logic        i_dac_req1,
  input  logic        i_dac_we0,
  input  logic        i_dac_we1,
  input  logic [31:0] i_dac_addr0,
  input  logic [31:0] i_dac_addr1,
  input  logic [31:0] i_dac_wdata0,
  input  logic [31:0] i_dac_wdata1,
  input  logic [1:0]  i_dac_size0,
  input  logic [1:0]  i_dac_size1,
  input  logic        i_dac_uns0,
  input  logic        i_dac_uns1,
  output logic        o_dac_ack0,
  output logic        o_dac_ack1,
  output logic        o_dac_err0,
  output logic        o_dac_err1,
  output logic [31:0] o_dac_rdata0,
  output logic [31:0] o_dac_rdata1,
  output logic [31:0] o_dac_mem_A,
  output logic [31:0] o_dac_mem_WD,
  output logic        o_dac_mem_WE,
  input  logic [31:0] i_dac_mem_RD
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE} state_e;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] merge_q, merge_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        elig0, elig1, gnt_valid, gnt_port;
  logic        sel_we, sel_uns, sel_err;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = rd;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] rd, input logic [31:0] wd,
                                             input logic [1:0] lo, input logic [1:0] size);
    logic [31:0] m;
    m = rd;
    case (size)
      2'b00: m[{lo, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lo[1]) m[31:16] = wd[15:0];
        else       m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    merge_lane = m;
  endfunction

  // Arbitration: a port in its ack cycle is not eligible, ties go to the port not granted last.
  always_comb begin
    elig0     = i_dac_req0 & ~ack_q[0];
    elig1     = i_dac_req1 & ~ack_q[1];
    gnt_valid = elig0 | elig1;
    gnt_port  = (elig0 & elig1) ? ~ptr_q : elig1;
    sel_we    = gnt_port ? i_dac_we1    : i_dac_we0;
    sel_addr  = gnt_port ? i_dac_addr1  : i_dac_addr0;
    sel_wdata = gnt_port ? i_dac_wdata1 : i_dac_wdata0;
    sel_size  = gnt_port ? i_dac_size1  : i_dac_size0;
    sel_uns   = gnt_port ? i_dac_uns1   : i_dac_uns0;
    sel_err   = (sel_size == 2'b11)
              | ((sel_size == 2'b01) & sel_addr[0])
              | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
              | (sel_addr[31:2] >= DEPTH_W);
  end

  always_ff @(posedge i_dac_clk or negedge i_dac_rst_n) begin
    if (!i_dac_rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      merge_q  <= 32'h0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      merge_q  <= merge_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_valid && !sel_err) state_d = S_ACCESS;
      S_ACCESS: state_d = (we_q && size_q != 2'b10) ? S_WRITE : S_IDLE;
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    merge_d  = merge_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          ptr_d   = gnt_port;
          port_d  = gnt_port;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          size_d  = sel_size;
          uns_d   = sel_uns;
          // Rejected access completes straight from IDLE without touching memory.
          if (sel_err) begin
            ack_d[gnt_port] = 1'b1;
            err_d[gnt_port] = 1'b1;
            if (gnt_port) rdata1_d = 32'h0;
            else          rdata0_d = 32'h0;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          ack_d[port_q] = 1'b1;
          if (port_q) rdata1_d = load_ext(i_dac_mem_RD, addr_q[1:0], size_q, uns_q);
          else        rdata0_d = load_ext(i_dac_mem_RD, addr_q[1:0], size_q, uns_q);
        end else if (size_q == 2'b10) begin
          ack_d[port_q] = 1'b1;
        end else begin
          merge_d = merge_lane(i_dac_mem_RD, wdata_q, addr_q[1:0], size_q);
        end
      end
      S_WRITE: ack_d[port_q] = 1'b1;
      default: ;
    endcase
  end

  // Memory strobes decode from state so reset removes WE without waiting for a clock.
  always_comb begin
    o_dac_mem_A  = 32'h0;
    o_dac_mem_WD = 32'h0;
    o_dac_mem_WE = 1'b0;
    case (state_q)
      S_ACCESS: begin
        o_dac_mem_A = {addr_q[31:2], 2'b00};
        if (we_q && size_q == 2'b10) begin
          o_dac_mem_WD = wdata_q;
          o_dac_mem_WE = 1'b1;
        end
      end
      S_WRITE: begin
        o_dac_mem_A  = {addr_q[31:2], 2'b00};
        o_dac_mem_WD = merge_q;
        o_dac_mem_WE = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_dac_ack0   = ack_q[0];
  assign o_dac_ack1   = ack_q[1];
  assign o_dac_err0   = err_q[0];
  assign o_dac_err1   = err_q[1];
  assign o_dac_rdata0 = rdata0_q;
  assign o_dac_rdata1 = rdata1_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl with a behavioural DataMemory and per-port response scoreboards.
module tb_dm_access_ctrl;

  localparam int DEPTH = 255;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, uns0 = 0, uns1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [1:0]  size0 = 0, size1 = 0;
  logic        ack0, ack1, err0, err1, mem_WE;
  logic [31:0] rdata0, rdata1, mem_A, mem_WD, mem_RD;

  logic [31:0] mem [0:DEPTH-1];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;
  logic [29:0] widx;

  exp_t sb0[$];
  exp_t sb1[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.DEPTH(DEPTH)) dut (
    .i_dac_clk(clk), .i_dac_rst_n(rst_n),
    .i_dac_req0(req0), .i_dac_req1(req1),
    .i_dac_we0(we0), .i_dac_we1(we1),
    .i_dac_addr0(addr0), .i_dac_addr1(addr1),
    .i_dac_wdata0(wdata0), .i_dac_wdata1(wdata1),
    .i_dac_size0(size0), .i_dac_size1(size1),
    .i_dac_uns0(uns0), .i_dac_uns1(uns1),
    .o_dac_ack0(ack0), .o_dac_ack1(ack1),
    .o_dac_err0(err0), .o_dac_err1(err1),
    .o_dac_rdata0(rdata0), .o_dac_rdata1(rdata1),
    .o_dac_mem_A(mem_A), .o_dac_mem_WD(mem_WD), .o_dac_mem_WE(mem_WE),
    .i_dac_mem_RD(mem_RD)
  );

  // DataMemory: combinational read, synchronous write; bench preloads share the write port.
  assign widx   = mem_A[31:2];
  assign mem_RD = (widx < 30'(DEPTH)) ? mem[widx[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_WE && widx < 30'(DEPTH)) mem[widx[7:0]] <= mem_WD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] size, input logic uns);
    if (p == 0) begin req0 = r; we0 = we; addr0 = addr; wdata0 = wd; size0 = size; uns0 = uns; end
    else        begin req1 = r; we1 = we; addr1 = addr; wdata1 = wd; size1 = size; uns1 = uns; end
  endtask

  // Single transaction on one port: checks latency, WE activity and the scoreboard entry.
  task automatic access(input string name, input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] size, input logic uns,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                        input int exp_wes);
    exp_t e, got_e;
    int   lat = -1;
    int   wes = 0;
    logic a;
    e.err = exp_err; e.rdata = exp_rd;
    if (p == 0) sb0.push_back(e); else sb1.push_back(e);
    @(posedge clk); #1;
    drive(p, 1'b1, we, addr, wd, size, uns);
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_WE) begin
        wes++;
        tests++;
        if (mem_A !== {addr[31:2], 2'b00}) begin
          fails++;
          $display("FAIL %s mem_A: got %h expected %h", name, mem_A, {addr[31:2], 2'b00});
        end
      end
      a = (p == 0) ? ack0 : ack1;
      if (a) begin
        lat = c;
        got_e.err   = (p == 0) ? err0 : err1;
        got_e.rdata = (p == 0) ? rdata0 : rdata1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      end
    end
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL %s timeout: no ack within 12 cycles", name);
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      if (p == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end else begin
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
      tests++;
      if (got_e.err !== e.err) begin
        fails++;
        $display("FAIL %s err: got %b expected %b", name, got_e.err, e.err);
      end
      if (!we || e.err) begin
        tests++;
        if (got_e.rdata !== e.rdata) begin
          fails++;
          $display("FAIL %s rdata: got %h expected %h", name, got_e.rdata, e.rdata);
        end
      end
    end
    tests++;
    if (wes != exp_wes) begin
      fails++;
      $display("FAIL %s we_cycles: got %0d expected %0d", name, wes, exp_wes);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ack0, ack1, err0, err1, mem_WE} !== 5'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0 ||
        mem_A !== 32'h0 || mem_WD !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b%b err=%b%b we=%b rd0=%h rd1=%h A=%h WD=%h expected all 0",
               ack0, ack1, err0, err1, mem_WE, rdata0, rdata1, mem_A, mem_WD);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    access("sw_word", 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0, 2, 1);
    tests++;
    if (mem[4] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_mem: got %h expected %h", mem[4], 32'hDEADBEEF);
    end
    access("lw_word", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 2, 0);
    access("lw_port1", 1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 2, 0);
  endtask

  task automatic test_byte();
    preload(8'd4, 32'h11223344);
    access("sb_rmw", 0, 1'b1, 32'h12, 32'h000000AA, 2'b00, 1'b0, 1'b0, 32'h0, 3, 1);
    tests++;
    if (mem[4] !== 32'h11AA3344) begin
      fails++;
      $display("FAIL sb_mem: got %h expected %h", mem[4], 32'h11AA3344);
    end
    access("lb", 0, 1'b0, 32'h12, 32'h0, 2'b00, 1'b0, 1'b0, 32'hFFFFFFAA, 2, 0);
    access("lbu", 0, 1'b0, 32'h12, 32'h0, 2'b00, 1'b1, 1'b0, 32'h000000AA, 2, 0);
    access("lb_lane0", 1, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 32'h00000044, 2, 0);
  endtask

  task automatic test_half();
    preload(8'd5, 32'h00001234);
    access("sh_rmw", 0, 1'b1, 32'h16, 32'h00008001, 2'b01, 1'b0, 1'b0, 32'h0, 3, 1);
    tests++;
    if (mem[5] !== 32'h80011234) begin
      fails++;
      $display("FAIL sh_mem: got %h expected %h", mem[5], 32'h80011234);
    end
    access("lh", 0, 1'b0, 32'h16, 32'h0, 2'b01, 1'b0, 1'b0, 32'hFFFF8001, 2, 0);
    access("lhu", 0, 1'b0, 32'h16, 32'h0, 2'b01, 1'b1, 1'b0, 32'h00008001, 2, 0);
  endtask

  task automatic test_errors();
    access("err_lw_misal", 0, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 1, 0);
    access("err_lh_odd", 0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0, 1, 0);
    access("err_size11", 1, 1'b1, 32'h10, 32'h12345678, 2'b11, 1'b0, 1'b1, 32'h0, 1, 0);
    access("err_range", 0, 1'b1, 32'(4 * DEPTH), 32'h1, 2'b10, 1'b0, 1'b1, 32'h0, 1, 0);
    access("ok_last_word", 0, 1'b0, 32'(4 * DEPTH - 4), 32'h0, 2'b10, 1'b0, 1'b0, mem[DEPTH-1], 2, 0);
  endtask

  // Both ports held with loads from reset: ack order must alternate starting at port 0.
  task automatic test_back_to_back();
    int   order[$];
    int   seen = 0;
    int   p;
    int   want;
    logic [31:0] exp0, exp1;
    exp0 = mem[4];
    exp1 = mem[5];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) order.push_back(i % 2);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0);
    for (int c = 0; c < 40 && seen < 6; c++) begin
      @(negedge clk);
      if (ack0 && ack1) begin
        tests++; fails++;
        $display("FAIL rr_both_ack: got ack0=1 ack1=1 expected one at a time");
      end
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        want = order.pop_front();
        seen++;
        tests++;
        if (p != want) begin
          fails++;
          $display("FAIL rr_order: ack %0d got port %0d expected port %0d", seen, p, want);
        end
        tests++;
        if ((p == 0 && rdata0 !== exp0) || (p == 1 && rdata1 !== exp1)) begin
          fails++;
          $display("FAIL rr_rdata: port %0d got %h expected %h", p,
                   (p == 0) ? rdata0 : rdata1, (p == 0) ? exp0 : exp1);
        end
        if (seen == 6) begin
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
          drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        end
      end
    end
    tests++;
    if (seen != 6) begin
      fails++;
      $display("FAIL rr_timeout: got %0d acks expected 6", seen);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_rmw();
    int acks = 0;
    preload(8'd6, 32'h55667788);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h19, 32'h00000099, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if (mem_WE !== 1'b1) begin
      fails++;
      $display("FAIL rst_write_cycle: got WE=%b expected 1", mem_WE);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_WE !== 1'b0) begin
      fails++;
      $display("FAIL rst_we_drop: got WE=%b expected 0", mem_WE);
    end
    repeat (2) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL rst_no_ack: got %0d acks expected 0", acks);
    end
    tests++;
    if (mem[6] !== 32'h55667788) begin
      fails++;
      $display("FAIL rst_mem_unchanged: got %h expected %h", mem[6], 32'h55667788);
    end
    access("lw_after_rst", 0, 1'b0, 32'h18, 32'h0, 2'b10, 1'b0, 1'b0, 32'h55667788, 2, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
